pmp_csr_writer: RTL and testbench

//  Write/configure side of the PMP: holds the pmpcfg/pmpaddr CSR state that the per-entry PMP address decoders consume.

---
 rtl/pmp_csr_writer_pkg.sv | 31 +++
 rtl/pmp_csr_writer_cfg_warl.sv | 35 +++
 rtl/pmp_csr_writer.sv | 168 ++++++++++++++++
 tb/tb_pmp_csr_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pmp_csr_writer_pkg.sv
// PMP CSR shared definitions: address-mode codes, CSR bases, cfg bit positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: pmp_amode_e (A field encodings), PMPCFG_BASE/PMPADDR_BASE,
// PRIV_M, and CFG_* bit positions inside a pmpcfg byte.
package pmp_pkg;

   typedef enum logic [1:0] {
      PMP_OFF   = 2'd0,
      PMP_TOR   = 2'd1,
      PMP_NA4   = 2'd2,
      PMP_NAPOT = 2'd3
   } pmp_amode_e;

   localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
   localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

   localparam logic [1:0]  PRIV_M = 2'b11;

   // Bit positions inside one pmpcfg byte.
   localparam int CFG_L      = 7;
   localparam int CFG_RSV_HI = 6;
   localparam int CFG_RSV_LO = 5;
   localparam int CFG_A_HI   = 4;
   localparam int CFG_A_LO   = 3;
   localparam int CFG_X      = 2;
   localparam int CFG_W      = 1;
   localparam int CFG_R      = 0;

endpackage

// File: rtl/pmp_csr_writer_cfg_warl.sv
// Per-byte pmpcfg legalizer: turns (old byte, written byte) into the byte to store.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
//
// Ports: old_cfg    - currently stored cfg byte
//        new_cfg    - byte lane of the CSR write data
//        stored_cfg - value to store (old value kept when the entry is locked)
//        changed    - stored_cfg differs from old_cfg
module pmp_cfg_warl
   import pmp_pkg::*;
(
   input  logic [7:0] old_cfg,
   input  logic [7:0] new_cfg,
   output logic [7:0] stored_cfg,
   output logic       changed
);

   logic [7:0] legal;

   always_comb begin
      legal                      = 8'h00;
      legal[CFG_L]               = new_cfg[CFG_L];
      legal[CFG_A_HI:CFG_A_LO]   = new_cfg[CFG_A_HI:CFG_A_LO];
      legal[CFG_X]               = new_cfg[CFG_X];
      legal[CFG_R]               = new_cfg[CFG_R];
      // R=0,W=1 is reserved: W only survives alongside R.
      legal[CFG_W]               = new_cfg[CFG_W] & new_cfg[CFG_R];
      legal[CFG_RSV_HI:CFG_RSV_LO] = 2'b00;

      // A locked byte is frozen until reset.
      stored_cfg = old_cfg[CFG_L] ? old_cfg : legal;
      changed    = (stored_cfg != old_cfg);
   end

endmodule

// File: rtl/pmp_csr_writer.sv
// PMP configuration store: pmpcfg/pmpaddr CSRs with lock and WARL handling.
// Latency: response (ack/rdata/illegal) and state update visible 1 cycle after request.
// Backpressure: none; one request per cycle is always accepted.
//
// Ports: clk, reset (sync, active-high)
//        CSRReq/CSRWe/CSRAdr/CSRWData/PrivMode - CSR request (M-mode only)
//        CSRAck/CSRRData/CSRIllegal            - registered response, old value returned
//        PMPUpdate                             - 1-cycle pulse when stored state changed
//        PMPCfg/PMPAdr                         - flattened per-entry cfg bytes and addresses
module pmp_csr_writer
   import pmp_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int PA_BITS     = 56,
   parameter int PMP_ENTRIES = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               CSRReq,
   input  logic                               CSRWe,
   input  logic [11:0]                        CSRAdr,
   input  logic [XLEN-1:0]                    CSRWData,
   input  logic [1:0]                         PrivMode,
   output logic                               CSRAck,
   output logic [XLEN-1:0]                    CSRRData,
   output logic                               CSRIllegal,
   output logic                               PMPUpdate,
   output logic [8*PMP_ENTRIES-1:0]           PMPCfg,
   output logic [(PA_BITS-2)*PMP_ENTRIES-1:0] PMPAdr
);

   localparam int NB = XLEN / 8;     // cfg bytes per pmpcfg CSR
   localparam int AW = PA_BITS - 2;  // stored pmpaddr width

   logic [7:0]             cfg_q [PMP_ENTRIES];
   logic [7:0]             cfg_d [PMP_ENTRIES];
   logic [AW-1:0]          adr_q [PMP_ENTRIES];
   logic [AW-1:0]          adr_d [PMP_ENTRIES];
   logic [PMP_ENTRIES-1:0] adr_lock;

   logic                   is_cfg;
   logic                   is_addr;
   logic                   illegal;
   logic                   wr;
   logic [3:0]             cfg_n;
   logic [11:0]            addr_off;
   logic [5:0]             addr_n;

   logic [7:0]             lane_old [NB];
   logic [7:0]             lane_new [NB];
   logic [NB-1:0]          lane_impl;
   logic [NB-1:0]          lane_chg;

   logic [XLEN-1:0]        rd_cfg;
   logic [AW-1:0]          rd_adr;
   logic [XLEN-1:0]        rdata;
   logic                   cfg_upd;
   logic                   adr_upd;

   // ---------------------------------------------------------------- decode
   always_comb begin
      cfg_n    = CSRAdr[3:0];
      is_cfg   = (CSRAdr[11:4] == PMPCFG_BASE[11:4]);
      addr_off = CSRAdr - PMPADDR_BASE;
      is_addr  = (addr_off < 12'd64);
      addr_n   = addr_off[5:0];
      // On RV64 only even pmpcfg numbers exist.
      illegal  = (PrivMode != PRIV_M) || ((XLEN == 64) && is_cfg && cfg_n[0]);
      wr       = CSRReq && CSRWe && !illegal;
   end

   // ------------------------------------------------------- cfg byte lanes
   // pmpcfgN lane b maps to entry 4N+b on both RV32 and RV64 (RV64 uses even N).
   always_comb begin
      rd_cfg = '0;
      for (int b = 0; b < NB; b++) begin
         lane_old[b]  = 8'h00;
         lane_impl[b] = 1'b0;
         for (int i = 0; i < PMP_ENTRIES; i++) begin
            if (i == 4 * int'(cfg_n) + b) begin
               lane_old[b]  = cfg_q[i];
               lane_impl[b] = 1'b1;
            end
         end
         rd_cfg[8*b +: 8] = lane_old[b];
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_lane
      pmp_cfg_warl u_warl (
         .old_cfg    (lane_old[b]),
         .new_cfg    (CSRWData[8*b +: 8]),
         .stored_cfg (lane_new[b]),
         .changed    (lane_chg[b])
      );
   end

   // ------------------------------------------------------ pmpaddr locking
   // An address is frozen by its own lock, or by the next entry being a
   // locked TOR region (which uses this address as its lower bound).
   for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_lock
      if (i == PMP_ENTRIES - 1) begin : g_last
         assign adr_lock[i] = cfg_q[i][CFG_L];
      end else begin : g_mid
         assign adr_lock[i] = cfg_q[i][CFG_L] |
                              (cfg_q[i+1][CFG_L] & (cfg_q[i+1][CFG_A_HI:CFG_A_LO] == PMP_TOR));
      end
   end

   // ------------------------------------------------------------ read path
   always_comb begin
      rd_adr = '0;
      for (int i = 0; i < PMP_ENTRIES; i++) begin
         if (i == int'(addr_n)) rd_adr = adr_q[i];
      end
      rdata = is_cfg ? rd_cfg : XLEN'(rd_adr);
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      cfg_d   = cfg_q;
      adr_d   = adr_q;
      adr_upd = 1'b0;
      for (int i = 0; i < PMP_ENTRIES; i++) begin
         for (int b = 0; b < NB; b++) begin
            if (wr && is_cfg && (i == 4 * int'(cfg_n) + b)) cfg_d[i] = lane_new[b];
         end
         if (wr && is_addr && (i == int'(addr_n)) && !adr_lock[i]) begin
            adr_d[i] = AW'(CSRWData);
         end
         if (adr_d[i] != adr_q[i]) adr_upd = 1'b1;
      end
      // Lanes mapping past the last entry have no storage and never count.
      cfg_upd = wr && is_cfg && |(lane_chg & lane_impl);
   end

   // ------------------------------------------------------------- flatten
   always_comb begin
      PMPCfg = '0;
      PMPAdr = '0;
      for (int i = 0; i < PMP_ENTRIES; i++) begin
         PMPCfg[8*i +: 8]   = cfg_q[i];
         PMPAdr[AW*i +: AW] = adr_q[i];
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PMP_ENTRIES; i++) begin
            cfg_q[i] <= 8'h00;
            adr_q[i] <= '0;
         end
         CSRAck     <= 1'b0;
         CSRRData   <= '0;
         CSRIllegal <= 1'b0;
         PMPUpdate  <= 1'b0;
      end else begin
         cfg_q      <= cfg_d;
         adr_q      <= adr_d;
         CSRAck     <= CSRReq;
         CSRIllegal <= CSRReq && illegal;
         CSRRData   <= (CSRReq && !illegal) ? rdata : '0;
         PMPUpdate  <= cfg_upd || adr_upd;
      end
   end

endmodule

// File: tb/tb_pmp_csr_writer.sv
// Self-checking bench for pmp_csr_writer (RV64, 56-bit PA, 16 entries).
// Latency: checks responses one cycle after each request.
// Backpressure: n/a.
module tb_pmp_csr_writer;

   localparam int XLEN    = 64;
   localparam int PA_BITS = 56;
   localparam int NE      = 16;
   localparam int AW      = PA_BITS - 2;

   localparam logic [1:0] M = 2'b11;
   localparam logic [1:0] S = 2'b01;

   logic                clk = 1'b0;
   logic                reset;
   logic                CSRReq;
   logic                CSRWe;
   logic [11:0]         CSRAdr;
   logic [XLEN-1:0]     CSRWData;
   logic [1:0]          PrivMode;
   logic                CSRAck;
   logic [XLEN-1:0]     CSRRData;
   logic                CSRIllegal;
   logic                PMPUpdate;
   logic [8*NE-1:0]     PMPCfg;
   logic [AW*NE-1:0]    PMPAdr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pmp_csr_writer #(.XLEN(XLEN), .PA_BITS(PA_BITS), .PMP_ENTRIES(NE)) dut (
      .clk        (clk),
      .reset      (reset),
      .CSRReq     (CSRReq),
      .CSRWe      (CSRWe),
      .CSRAdr     (CSRAdr),
      .CSRWData   (CSRWData),
      .PrivMode   (PrivMode),
      .CSRAck     (CSRAck),
      .CSRRData   (CSRRData),
      .CSRIllegal (CSRIllegal),
      .PMPUpdate  (PMPUpdate),
      .PMPCfg     (PMPCfg),
      .PMPAdr     (PMPAdr)
   );

   typedef struct {
      logic        we;
      logic [11:0] adr;
      logic [63:0] wdata;
      logic [1:0]  priv;
      logic [63:0] rdata;
      logic        ill;
      logic        upd;
   } vec_t;

   vec_t vecs [$];

   task automatic addv(input logic we, input logic [11:0] adr, input logic [63:0] wd,
                       input logic [1:0] pv, input logic [63:0] rd, input logic ill,
                       input logic upd);
      vec_t v;
      v.we = we; v.adr = adr; v.wdata = wd; v.priv = pv;
      v.rdata = rd; v.ill = ill; v.upd = upd;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [11:0] adr, input logic [63:0] wd,
                        input logic [1:0] pv);
      CSRReq = 1'b1; CSRWe = we; CSRAdr = adr; CSRWData = wd; PrivMode = pv;
   endtask

   task automatic idle();
      CSRReq = 1'b0; CSRWe = 1'b0; CSRAdr = 12'h000; CSRWData = '0; PrivMode = M;
   endtask

   function automatic logic [63:0] cfg_byte(input int i);
      return 64'(PMPCfg[8*i +: 8]);
   endfunction

   function automatic logic [63:0] adr_ent(input int i);
      return 64'(PMPAdr[AW*i +: AW]);
   endfunction

   initial begin
      // Table: state accumulates from one vector to the next.
      //    we    adr      wdata                   priv rdata                   ill   upd
      addv(1'b0, 12'h3A0, 64'h0,                  M, 64'h0,                  1'b0, 1'b0);
      addv(1'b0, 12'h3B0, 64'h0,                  M, 64'h0,                  1'b0, 1'b0);
      addv(1'b1, 12'h3A0, 64'h0F1F,               M, 64'h0,                  1'b0, 1'b1);
      addv(1'b0, 12'h3A0, 64'h0,                  M, 64'h0F1F,               1'b0, 1'b0);
      addv(1'b1, 12'h3A0, 64'h0F1F,               M, 64'h0F1F,               1'b0, 1'b0);
      addv(1'b1, 12'h3A0, 64'h0F02,               M, 64'h0F1F,               1'b0, 1'b1);
      addv(1'b1, 12'h3A0, 64'h0F67,               M, 64'h0F00,               1'b0, 1'b1);
      addv(1'b0, 12'h3A0, 64'h0,                  M, 64'h0F07,               1'b0, 1'b0);
      addv(1'b1, 12'h3A0, 64'h8807,               M, 64'h0F07,               1'b0, 1'b1);
      addv(1'b1, 12'h3B0, 64'h1234,               M, 64'h0,                  1'b0, 1'b0);
      addv(1'b1, 12'h3B1, 64'h5678,               M, 64'h0,                  1'b0, 1'b0);
      addv(1'b1, 12'h3B2, 64'h9,                  M, 64'h0,                  1'b0, 1'b1);
      addv(1'b0, 12'h3B2, 64'h0,                  M, 64'h9,                  1'b0, 1'b0);
      addv(1'b0, 12'h3B0, 64'h0,                  M, 64'h0,                  1'b0, 1'b0);
      addv(1'b1, 12'h3A0, 64'h0003,               M, 64'h8807,               1'b0, 1'b1);
      addv(1'b0, 12'h3A0, 64'h0,                  M, 64'h8803,               1'b0, 1'b0);
      addv(1'b1, 12'h3A0, 64'h0003,               M, 64'h8803,               1'b0, 1'b0);
      addv(1'b1, 12'h3B3, 64'hFF,                 S, 64'h0,                  1'b1, 1'b0);
      addv(1'b0, 12'h3B3, 64'h0,                  M, 64'h0,                  1'b0, 1'b0);
      addv(1'b1, 12'h3A1, 64'hFFFF,               M, 64'h0,                  1'b1, 1'b0);
      addv(1'b0, 12'h3A0, 64'h0,                  S, 64'h0,                  1'b1, 1'b0);
      addv(1'b1, 12'h3A4, 64'h1F1F1F1F1F1F1F1F,   M, 64'h0,                  1'b0, 1'b0);
      addv(1'b0, 12'h3A4, 64'h0,                  M, 64'h0,                  1'b0, 1'b0);
      addv(1'b1, 12'h3C4, 64'hAB,                 M, 64'h0,                  1'b0, 1'b0);
      addv(1'b0, 12'h3C4, 64'h0,                  M, 64'h0,                  1'b0, 1'b0);
      addv(1'b1, 12'h3A2, 64'h8800000000000000,   M, 64'h0,                  1'b0, 1'b1);
      addv(1'b1, 12'h3BF, 64'h55,                 M, 64'h0,                  1'b0, 1'b0);
      addv(1'b1, 12'h3BE, 64'h66,                 M, 64'h0,                  1'b0, 1'b0);
      addv(1'b1, 12'h3BD, 64'h77,                 M, 64'h0,                  1'b0, 1'b1);
      addv(1'b1, 12'h3A2, 64'h0,                  M, 64'h8800000000000000,   1'b0, 1'b0);
      addv(1'b1, 12'h3B4, 64'hFFFFFFFFFFFFFFFF,   M, 64'h0,                  1'b0, 1'b1);
      addv(1'b0, 12'h3B4, 64'h0,                  M, 64'h003FFFFFFFFFFFFF,   1'b0, 1'b0);

      // ---------------------------------------------------------- reset
      reset = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack",  64'(CSRAck),     64'h0);
      chk("rst_rd",   CSRRData,        64'h0);
      chk("rst_ill",  64'(CSRIllegal), 64'h0);
      chk("rst_upd",  64'(PMPUpdate),  64'h0);
      chk("rst_cfg",  64'(|PMPCfg),    64'h0);
      chk("rst_adr",  64'(|PMPAdr),    64'h0);
      reset = 1'b0;

      // --------------------------------------------------- vector table
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].priv);
         @(posedge clk);
         @(negedge clk);
         idle();
         chk($sformatf("v%0d_ack", i), 64'(CSRAck),     64'h1);
         chk($sformatf("v%0d_rd",  i), CSRRData,        vecs[i].rdata);
         chk($sformatf("v%0d_ill", i), 64'(CSRIllegal), 64'(vecs[i].ill));
         chk($sformatf("v%0d_upd", i), 64'(PMPUpdate),  64'(vecs[i].upd));
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_idle_ack", i), 64'(CSRAck),    64'h0);
         chk($sformatf("v%0d_idle_upd", i), 64'(PMPUpdate), 64'h0);
      end

      // Flattened outputs after the table.
      chk("cfg0",  cfg_byte(0),  64'h03);
      chk("cfg1",  cfg_byte(1),  64'h88);
      chk("cfg15", cfg_byte(15), 64'h88);
      chk("adr0",  adr_ent(0),   64'h0);
      chk("adr1",  adr_ent(1),   64'h0);
      chk("adr2",  adr_ent(2),   64'h9);
      chk("adr4",  adr_ent(4),   64'h003FFFFFFFFFFFFF);
      chk("adr13", adr_ent(13),  64'h77);
      chk("adr14", adr_ent(14),  64'h0);
      chk("adr15", adr_ent(15),  64'h0);

      // -------------------------------- back-to-back write then read
      drive(1'b1, 12'h3B5, 64'hAA, M);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_w_ack", 64'(CSRAck),    64'h1);
      chk("b2b_w_rd",  CSRRData,       64'h0);
      chk("b2b_w_upd", 64'(PMPUpdate), 64'h1);
      chk("b2b_adr5",  adr_ent(5),     64'hAA);
      drive(1'b0, 12'h3B5, 64'h0, M);
      @(posedge clk);
      @(negedge clk);
      idle();
      chk("b2b_r_ack", 64'(CSRAck),    64'h1);
      chk("b2b_r_rd",  CSRRData,       64'hAA);
      chk("b2b_r_upd", 64'(PMPUpdate), 64'h0);

      // ---------------------------- reset mid-sequence, beats request
      drive(1'b1, 12'h3B6, 64'h1, M);
      @(posedge clk);
      @(negedge clk);
      chk("mid_ack", 64'(CSRAck),    64'h1);
      chk("mid_upd", 64'(PMPUpdate), 64'h1);
      reset = 1'b1;
      drive(1'b1, 12'h3A0, 64'h1F, M);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle();
      chk("mrst_ack", 64'(CSRAck),     64'h0);
      chk("mrst_rd",  CSRRData,        64'h0);
      chk("mrst_ill", 64'(CSRIllegal), 64'h0);
      chk("mrst_upd", 64'(PMPUpdate),  64'h0);
      chk("mrst_cfg", 64'(|PMPCfg),    64'h0);
      chk("mrst_adr", 64'(|PMPAdr),    64'h0);

      // Lock is gone after reset: pmpaddr0 now writable.
      drive(1'b1, 12'h3B0, 64'h1234, M);
      @(posedge clk);
      @(negedge clk);
      idle();
      chk("post_upd",  64'(PMPUpdate), 64'h1);
      chk("post_adr0", adr_ent(0),     64'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
